// File: rtl/kmp_search_ctrl.sv
// KMP string-search sequencer: loads the pattern from its ROM, builds the LPS table,
// then scans the text ROM once and counts overlapping matches.
module kmp_search_ctrl #(
   parameter int PAT_LEN  = 5,
   parameter int PAT_AW   = 3,
   parameter int TEXT_LEN = 11064,
   parameter int TEXT_AW  = 14,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inicio,
   input  logic [7:0]         patron,
   input  logic [7:0]         texto,
   output logic [PAT_AW-1:0]  addr_patron,
   output logic [TEXT_AW-1:0] addr_texto,
   output logic [CNT_W-1:0]   instancias,
   output logic               busy,
   output logic               done,
   output logic [3:0]         actual_state
);
   localparam int IW    = $clog2(PAT_LEN + 1);
   localparam int TW    = $clog2(TEXT_LEN + 1);
   localparam int DEPTH = 1 << IW;
   localparam logic [IW-1:0] PL   = IW'(PAT_LEN);
   localparam logic [IW-1:0] LAST = IW'(PAT_LEN - 1);
   localparam logic [IW-1:0] ONE  = IW'(1);
   localparam logic [TW-1:0] TL   = TW'(TEXT_LEN);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_LOAD  = 4'd1,
      S_BUILD = 4'd2,
      S_FETCH = 4'd3,
      S_CMP   = 4'd4,
      S_DONE  = 4'd5
   } state_t;

   state_t state, state_nx;

   // Arrays are padded to a power of two so every index register addresses them exactly.
   logic [7:0]    pat [0:DEPTH-1];
   logic [IW-1:0] lps [0:DEPTH-1];
   logic [IW-1:0] lc, i, len, j;
   logic [TW-1:0] t, t_clamp;
   logic          char_eq;

   assign char_eq = (texto == pat[j]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: if (inicio) state_nx = S_LOAD;
         S_LOAD:         if (lc == PL) state_nx = S_BUILD;
         S_BUILD:        if (i == PL) state_nx = S_FETCH;
         S_FETCH:        state_nx = (t == TL) ? S_DONE : S_CMP;
         // A mismatch with j!=0 stays here: the ROM still holds char t.
         S_CMP:          if (char_eq || (j == '0)) state_nx = S_FETCH;
         default:        state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instancias <= '0;
         lc         <= '0;
         i          <= '0;
         len        <= '0;
         j          <= '0;
         t          <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            pat[k] <= '0;
            lps[k] <= '0;
         end
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (inicio) begin
                  instancias <= '0;
                  lc         <= '0;
                  i          <= '0;
                  len        <= '0;
                  j          <= '0;
                  t          <= '0;
               end
            end
            S_LOAD: begin
               // ROM data for address lc-1 arrives while lc is presented.
               if (lc != '0) pat[lc - ONE] <= patron;
               if (lc == PL) begin
                  i      <= ONE;
                  len    <= '0;
                  lps[0] <= '0;
               end else begin
                  lc <= lc + ONE;
               end
            end
            S_BUILD: begin
               if (i != PL) begin
                  if (pat[i] == pat[len]) begin
                     lps[i] <= len + ONE;
                     len    <= len + ONE;
                     i      <= i + ONE;
                  end else if (len != '0) begin
                     len <= lps[len - ONE];
                  end else begin
                     lps[i] <= '0;
                     i      <= i + ONE;
                  end
               end
            end
            S_CMP: begin
               if (char_eq) begin
                  t <= t + TW'(1);
                  if (j == LAST) begin
                     if (instancias != '1) instancias <= instancias + CNT_W'(1);
                     j <= lps[LAST];
                  end else begin
                     j <= j + ONE;
                  end
               end else if (j != '0) begin
                  j <= lps[j - ONE];
               end else begin
                  t <= t + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // At t==TEXT_LEN the scan ends without a read, so the address is held in range.
   assign t_clamp      = (t < TL) ? t : (TL - TW'(1));
   assign addr_texto   = TEXT_AW'(t_clamp);
   assign addr_patron  = ((state == S_LOAD) && (lc != PL)) ? PAT_AW'(lc) : '0;
   assign busy         = (state == S_LOAD) || (state == S_BUILD) ||
                         (state == S_FETCH) || (state == S_CMP);
   assign done         = (state == S_DONE);
   assign actual_state = state;

endmodule
